// File: rtl/word_byte_sequencer_pkg.sv
// Shared types and constants for the word-to-byte sequencer.
// Optional lane-enable support is selected by WORD_BYTE_SEQ_BYTE_EN_EN.
package word_byte_sequencer_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;

    typedef logic [1:0] byteIdx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } seqState_t;

    // A bus word seen either as one 32-bit value or as byte3..byte0.
    typedef union packed {
        logic [WORD_BYTES*BYTE_W-1:0]      data;
        logic [WORD_BYTES-1:0][BYTE_W-1:0] bytes;
    } genericUnion_t;

endpackage

// File: rtl/word_byte_lane_pick.sv
// Finds the next enabled byte lane in the selected direction and flags
// whether that lane is the final enabled one. Used with WORD_BYTE_SEQ_BYTE_EN_EN.
module word_byte_lane_pick
    import word_byte_sequencer_pkg::*;
(
    input  logic [1:0] cur_idx,
    input  logic [3:0] mask,
    input  logic       msb_first,
    input  logic       first_sel,
    output logic [1:0] next_idx,
    output logic       is_last
);

    always_comb begin
        next_idx = cur_idx;
        is_last  = 1'b1;
        // MSB-first walks downward: keep the highest candidate below cur_idx.
        for (int l = 0; l < WORD_BYTES; l++) begin
            if (msb_first && mask[l] &&
                (l < int'(cur_idx) || (first_sel && l == int'(cur_idx))))
                next_idx = byteIdx_t'(l);
        end
        for (int l = WORD_BYTES - 1; l >= 0; l--) begin
            if (!msb_first && mask[l] &&
                (l > int'(cur_idx) || (first_sel && l == int'(cur_idx))))
                next_idx = byteIdx_t'(l);
        end
        for (int l = 0; l < WORD_BYTES; l++) begin
            if (mask[l] && (msb_first ? (l < int'(next_idx)) : (l > int'(next_idx))))
                is_last = 1'b0;
        end
    end

endmodule

// File: rtl/word_byte_sequencer.sv
// Serializes 32-bit words into a byte stream with valid/ready on both sides.
// Define WORD_BYTE_SEQ_BYTE_EN_EN to add per-lane enables (inByteEn).
//
// state | meaning
// IDLE  | no word held; inReady high
// SEND  | holding a word, presenting outByte with outValid high
module word_byte_sequencer #(
    parameter int WORD_BYTES = 4,
    parameter int BYTE_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WORD_BYTES*BYTE_W-1:0] inWord,
`ifdef WORD_BYTE_SEQ_BYTE_EN_EN
    input  logic [WORD_BYTES-1:0]        inByteEn,
`endif
    input  logic                         inValid,
    output logic                         inReady,
    input  logic                         msbFirst,
    output logic [BYTE_W-1:0]            outByte,
    output logic                         outValid,
    output logic                         outLast,
    input  logic                         outReady,
    output logic                         busy
);
    import word_byte_sequencer_pkg::seqState_t;
    import word_byte_sequencer_pkg::genericUnion_t;
    import word_byte_sequencer_pkg::byteIdx_t;
    import word_byte_sequencer_pkg::IDLE;
    import word_byte_sequencer_pkg::SEND;

    if (WORD_BYTES != word_byte_sequencer_pkg::WORD_BYTES ||
        BYTE_W != word_byte_sequencer_pkg::BYTE_W) begin : g_bad_cfg
        $error("word_byte_sequencer: lane layout is fixed to 4 x 8 bits");
    end

    seqState_t     state_q, state_d;
    genericUnion_t word_q, word_d;
    logic          msb_q, msb_d;
    byteIdx_t      idx_q, idx_d;
    logic          last_q, last_d;

    logic          last_hs;
    logic          accept;
    byteIdx_t      start_idx;
    byteIdx_t      first_idx;
    byteIdx_t      step_idx;
    logic          first_last;
    logic          step_last;
    logic          empty_word;

    assign start_idx = msbFirst ? 2'd3 : 2'd0;

`ifdef WORD_BYTE_SEQ_BYTE_EN_EN
    logic [3:0] en_q, en_d;

    word_byte_lane_pick u_first_pick (
        .cur_idx   (start_idx),
        .mask      (inByteEn),
        .msb_first (msbFirst),
        .first_sel (1'b1),
        .next_idx  (first_idx),
        .is_last   (first_last)
    );

    word_byte_lane_pick u_step_pick (
        .cur_idx   (idx_q),
        .mask      (en_q),
        .msb_first (msb_q),
        .first_sel (1'b0),
        .next_idx  (step_idx),
        .is_last   (step_last)
    );

    // An all-disabled word is consumed without ever entering SEND.
    assign empty_word = (inByteEn == 4'b0000);
`else
    assign first_idx  = start_idx;
    assign first_last = 1'b0;
    assign step_idx   = msb_q ? (idx_q - 2'd1) : (idx_q + 2'd1);
    assign step_last  = msb_q ? (step_idx == 2'd0) : (step_idx == 2'd3);
    assign empty_word = 1'b0;
`endif

    assign outValid = (state_q == SEND);
    assign busy     = outValid;
    assign outLast  = outValid && last_q;
    assign outByte  = outValid ? word_q.bytes[idx_q] : '0;
    assign last_hs  = outValid && outReady && outLast;
    assign inReady  = (state_q == IDLE) || last_hs;
    assign accept   = inValid && inReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            msb_q   <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
`ifdef WORD_BYTE_SEQ_BYTE_EN_EN
            en_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            msb_q   <= msb_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef WORD_BYTE_SEQ_BYTE_EN_EN
            en_q    <= en_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        msb_d   = msb_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef WORD_BYTE_SEQ_BYTE_EN_EN
        en_d    = en_q;
`endif
        case (state_q)
            IDLE: ;
            SEND: begin
                if (outReady) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d  = step_idx;
                        last_d = step_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A load on the final-byte handshake overrides the return to IDLE.
        if (accept) begin
            word_d  = inWord;
            msb_d   = msbFirst;
            idx_d   = first_idx;
            last_d  = first_last;
            state_d = empty_word ? IDLE : SEND;
`ifdef WORD_BYTE_SEQ_BYTE_EN_EN
            en_d    = inByteEn;
`endif
        end
    end

endmodule
